// File: rtl/core_if_fetch_pkg.sv
// Shared types for the instruction fetch unit.
// Holds the FSM encoding, the buffer entry layout and PC helpers.
package core_if_fetch_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        IFU_BOOT     = 2'd0,
        IFU_RUN      = 2'd1,
        IFU_ERR_WAIT = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
        logic              err;
    } ibuf_entry_t;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] a
    );
        return {a[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] next_word(
        input logic [XLEN-1:0] a
    );
        return a + XLEN'(4);
    endfunction

endpackage

// File: rtl/core_if_ibuf.sv
// Instruction buffer: DEPTH-entry FIFO of {inst, pc, err}.
// Ports: i_clear (sync flush), i_push/i_push_data, i_pop, o_head, o_count, o_full, o_empty.
module core_if_ibuf
    import core_if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  ibuf_entry_t              i_push_data,
    input  logic                     i_pop,
    output ibuf_entry_t              o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    ibuf_entry_t       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     rd_ptr_d;
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_push  = i_push && !i_clear;
        do_pop   = i_pop && !i_clear && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == (AW+1)'(DEPTH));

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(i_push && !i_clear && o_full && !i_pop)
    );

    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(i_pop && !i_clear && o_empty)
    );

endmodule

// File: rtl/core_if_fetch.sv
// Instruction fetch: in-order word requests, buffered responses, valid/ready to ID.
// Ports: ifu_req/rsp bus pair, i_flush/i_flush_pc redirect, o_inst* toward decode.
module core_if_fetch
    import core_if_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = IFU_RESET_PC,
    parameter int              IBUF_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_ifu_req_valid,
    input  logic              i_ifu_req_ready,
    output logic [XLEN-1:0]   o_ifu_req_addr,
    input  logic              i_ifu_rsp_valid,
    output logic              o_ifu_rsp_ready,
    input  logic [INST_W-1:0] i_ifu_rsp_inst,
    input  logic              i_ifu_rsp_err,
    input  logic              i_flush,
    input  logic [XLEN-1:0]   i_flush_pc,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [INST_W-1:0] o_inst,
    output logic [XLEN-1:0]   o_inst_pc,
    output logic              o_inst_err
);

    localparam int CW = $clog2(IBUF_DEPTH + MAX_OUTSTANDING + 1) + 1;
    localparam int BW = $clog2(IBUF_DEPTH) + 1;

    localparam logic [XLEN-1:0] BOOT_PC = {RESET_PC[XLEN-1:2], 2'b00};

    ifu_state_e      state_q;
    ifu_state_e      state_d;
    logic            req_valid_q;
    logic            req_valid_d;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] req_addr_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] rsp_pc_d;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   outstanding_d;
    logic [CW-1:0]   kill_cnt_q;
    logic [CW-1:0]   kill_cnt_d;

    ibuf_entry_t     push_entry;
    ibuf_entry_t     head;
    logic [BW-1:0]   ibuf_count;
    logic            ibuf_full;
    logic            ibuf_empty;

    logic            req_fire;
    logic            rsp_push;
    logic            inst_pop;
    logic [CW-1:0]   credit_used;
    logic            credit_ok;
    logic            issue;

    // Credit counts every slot a response could still land in:
    // accepted requests, buffered entries and the request on the bus.
    always_comb begin
        req_fire    = req_valid_q && i_ifu_req_ready;
        rsp_push    = i_ifu_rsp_valid && (kill_cnt_q == '0) && !i_flush;
        credit_used = outstanding_q + CW'(ibuf_count) + CW'(req_valid_q);
        credit_ok   = (credit_used < CW'(IBUF_DEPTH)) &&
                      (outstanding_q < CW'(MAX_OUTSTANDING));
        issue       = (state_q == IFU_RUN) && !i_flush &&
                      (!req_valid_q || req_fire) && credit_ok;
    end

    always_comb begin
        state_d       = state_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(i_ifu_rsp_valid);
        kill_cnt_d    = kill_cnt_q;

        unique case (state_q)
            IFU_BOOT: begin
                state_d = IFU_RUN;
            end
            IFU_RUN: begin
                if (rsp_push && i_ifu_rsp_err) begin
                    state_d = IFU_ERR_WAIT;
                end
            end
            IFU_ERR_WAIT: begin
                state_d = IFU_ERR_WAIT;
            end
            default: begin
                state_d = IFU_RUN;
            end
        endcase

        if (req_fire) begin
            req_valid_d = 1'b0;
        end
        if (issue) begin
            req_valid_d = 1'b1;
            req_addr_d  = fetch_pc_q;
            fetch_pc_d  = next_word(fetch_pc_q);
        end

        if (rsp_push) begin
            rsp_pc_d = next_word(rsp_pc_q);
        end

        if (i_flush) begin
            // Everything accepted or still waiting on the bus is stale;
            // a response returning this cycle is already dropped.
            state_d    = IFU_RUN;
            fetch_pc_d = word_align(i_flush_pc);
            rsp_pc_d   = word_align(i_flush_pc);
            kill_cnt_d = outstanding_q + CW'(req_valid_q)
                         - CW'(i_ifu_rsp_valid);
        end else if (i_ifu_rsp_valid && (kill_cnt_q != '0)) begin
            kill_cnt_d = kill_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IFU_BOOT;
            req_valid_q   <= 1'b0;
            req_addr_q    <= BOOT_PC;
            fetch_pc_q    <= BOOT_PC;
            rsp_pc_q      <= BOOT_PC;
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
        end
    end

    always_comb begin
        push_entry.inst = i_ifu_rsp_inst;
        push_entry.pc   = rsp_pc_q;
        push_entry.err  = i_ifu_rsp_err;
    end

    core_if_ibuf #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (i_flush),
        .i_push      (rsp_push),
        .i_push_data (push_entry),
        .i_pop       (inst_pop),
        .o_head      (head),
        .o_count     (ibuf_count),
        .o_full      (ibuf_full),
        .o_empty     (ibuf_empty)
    );

    assign o_ifu_req_valid = req_valid_q;
    assign o_ifu_req_addr  = req_addr_q;
    assign o_ifu_rsp_ready = 1'b1;

    assign o_inst_valid = !ibuf_empty && !i_flush;
    assign inst_pop     = o_inst_valid && i_inst_ready;
    assign o_inst       = head.inst;
    assign o_inst_pc    = head.pc;
    assign o_inst_err   = head.err;

    a_credit_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(rsp_push && ibuf_full && !inst_pop)
    );

    a_req_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (req_valid_q && !i_ifu_req_ready) |=>
        (req_valid_q && $stable(req_addr_q))
    );

endmodule

// File: tb/tb_core_if_fetch.sv
// Randomized scoreboard bench for core_if_fetch.
// Bus model tags requests by flush epoch; monitor checks ID output in order.
module tb_core_if_fetch;
    import core_if_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int DEPTH = 2;
    localparam int MAXO  = 2;

    logic        clk;
    logic        rst_n;
    logic        o_ifu_req_valid;
    logic        i_ifu_req_ready;
    logic [31:0] o_ifu_req_addr;
    logic        i_ifu_rsp_valid;
    logic        o_ifu_rsp_ready;
    logic [31:0] i_ifu_rsp_inst;
    logic        i_ifu_rsp_err;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_err;

    core_if_fetch #(
        .RESET_PC        (RST_PC),
        .IBUF_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .o_ifu_req_valid (o_ifu_req_valid),
        .i_ifu_req_ready (i_ifu_req_ready),
        .o_ifu_req_addr  (o_ifu_req_addr),
        .i_ifu_rsp_valid (i_ifu_rsp_valid),
        .o_ifu_rsp_ready (o_ifu_rsp_ready),
        .i_ifu_rsp_inst  (i_ifu_rsp_inst),
        .i_ifu_rsp_err   (i_ifu_rsp_err),
        .i_flush         (i_flush),
        .i_flush_pc      (i_flush_pc),
        .o_inst_valid    (o_inst_valid),
        .i_inst_ready    (i_inst_ready),
        .o_inst          (o_inst),
        .o_inst_pc       (o_inst_pc),
        .o_inst_err      (o_inst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
        logic        err;
    } bus_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    bus_t busq[$];
    exp_t expq[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int epoch = 0;
    int pend_epoch = 0;
    int err_cyc = -1;
    int first_valid_cyc = -1;
    logic [31:0] exp_addr;
    logic        mon_en = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_fire = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        got_first = 1'b0;
    logic [31:0] first_pc = '0;
    logic [31:0] err_pc = '0;
    logic        saw_wrap = 1'b0;

    int p_req_rdy = 0;
    int p_inst_rdy = 100;
    int p_flush = 0;
    int lat_min = 1;
    int lat_max = 1;
    logic        err_addr_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic        err_rand = 1'b0;
    logic        force_flush = 1'b0;
    logic [31:0] force_pc = '0;

    function automatic logic [31:0] mem_inst(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16]};
    endfunction

    function automatic bit chance(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: one evaluation per cycle, inputs stable.
    always @(negedge clk) begin
        logic fire;
        logic held;
        logic newreq;
        bus_t b;
        exp_t e;
        if (rst_n && mon_en) begin
            fire = o_ifu_req_valid && i_ifu_req_ready;
            check("inst_valid", 32'(o_inst_valid),
                  32'(expq.size() > 0 && !i_flush));
            check("credit", 32'(busq.size() + expq.size()
                  + int'(o_ifu_req_valid) <= DEPTH), 32'd1);
            check("max_out", 32'(busq.size() <= MAXO), 32'd1);
            check("rsp_ready", 32'(o_ifu_rsp_ready), 32'd1);
            if (o_inst_valid && first_valid_cyc < 0)
                first_valid_cyc = cyc;
            if (o_inst_valid && i_inst_ready) begin
                check("pop_nonempty", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("inst", o_inst, e.inst);
                    check("inst_pc", o_inst_pc, e.pc);
                    check("inst_err", 32'(o_inst_err), 32'(e.err));
                    if (!got_first) begin
                        got_first = 1'b1;
                        first_pc = o_inst_pc;
                    end
                    if (o_inst_err) err_pc = o_inst_pc;
                end
            end
            held = prev_valid && !prev_fire;
            if (held) begin
                check("req_hold_valid", 32'(o_ifu_req_valid), 32'd1);
                check("req_hold_addr", o_ifu_req_addr, prev_addr);
            end
            newreq = o_ifu_req_valid && !held;
            if (err_cyc >= 0 && cyc >= err_cyc + 2)
                check("no_req_in_err", 32'(newreq), 32'd0);
            if (newreq) begin
                check("req_addr", o_ifu_req_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
                pend_epoch = epoch;
                if (o_ifu_req_addr == 32'h0) saw_wrap = 1'b1;
            end
            if (fire) begin
                b.addr = o_ifu_req_addr;
                b.epoch = pend_epoch;
                b.due = cyc + int'($urandom_range(lat_max, lat_min));
                b.err = (err_addr_en && o_ifu_req_addr == err_addr) ||
                        (err_rand && o_ifu_req_addr[6:2] == 5'h0b);
                busq.push_back(b);
            end
            if (i_ifu_rsp_valid) begin
                check("rsp_expected", 32'(busq.size() > 0), 32'd1);
                if (busq.size() > 0) begin
                    b = busq.pop_front();
                    if (b.epoch == epoch && !i_flush) begin
                        e.inst = mem_inst(b.addr);
                        e.pc = b.addr;
                        e.err = b.err;
                        expq.push_back(e);
                        if (b.err && err_cyc < 0) err_cyc = cyc;
                    end
                end
            end
            if (i_flush) begin
                expq.delete();
                epoch++;
                exp_addr = {i_flush_pc[31:2], 2'b00};
                err_cyc = -1;
                got_first = 1'b0;
            end
            prev_valid = o_ifu_req_valid;
            prev_fire = fire;
            prev_addr = o_ifu_req_addr;
        end
    end

    task automatic drive();
        cyc++;
        i_ifu_req_ready = chance(p_req_rdy);
        i_inst_ready = chance(p_inst_rdy);
        if (busq.size() > 0 && busq[0].due <= cyc) begin
            i_ifu_rsp_valid = 1'b1;
            i_ifu_rsp_inst = mem_inst(busq[0].addr);
            i_ifu_rsp_err = busq[0].err;
        end else begin
            i_ifu_rsp_valid = 1'b0;
            i_ifu_rsp_inst = $urandom;
            i_ifu_rsp_err = 1'b0;
        end
        i_flush = 1'b0;
        i_flush_pc = $urandom;
        if (force_flush) begin
            i_flush = 1'b1;
            i_flush_pc = force_pc;
            force_flush = 1'b0;
        end else if (chance(p_flush)) begin
            i_flush = 1'b1;
            if (chance(20))
                i_flush_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            else
                i_flush_pc = RST_PC + 32'($urandom_range(4095, 0));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    task automatic flush_to(input logic [31:0] pc);
        force_flush = 1'b1;
        force_pc = pc;
        step(1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        i_ifu_req_ready = 1'b0;
        i_ifu_rsp_valid = 1'b0;
        i_ifu_rsp_inst = '0;
        i_ifu_rsp_err = 1'b0;
        i_flush = 1'b0;
        i_flush_pc = '0;
        i_inst_ready = 1'b0;
        exp_addr = RST_PC;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(o_ifu_req_valid), 32'd0);
        check("rst_req_addr", o_ifu_req_addr, RST_PC);
        check("rst_inst_valid", 32'(o_inst_valid), 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_inst_pc", o_inst_pc, 32'd0);
        check("rst_inst_err", 32'(o_inst_err), 32'd0);

        // Bus stalled: first request must hold at the reset PC.
        p_req_rdy = 0;
        p_inst_rdy = 100;
        lat_min = 1;
        lat_max = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        cyc = -1;
        drive();
        step(7);
        check("stall_valid", 32'(o_ifu_req_valid), 32'd1);
        check("stall_addr", o_ifu_req_addr, RST_PC);

        // Streaming with a 1-cycle bus.
        p_req_rdy = 100;
        step(30);
        check("first_valid_cyc", 32'(first_valid_cyc), 32'd10);

        // ID back-pressure.
        p_inst_rdy = 0;
        step(12);
        check("bp_no_req", 32'(o_ifu_req_valid), 32'd0);
        check("bp_inst_valid", 32'(o_inst_valid), 32'd1);
        p_inst_rdy = 100;
        step(10);

        // Flush with two requests in flight.
        lat_min = 3;
        lat_max = 3;
        step(8);
        n = 0;
        while (busq.size() < 2 && n < 30) begin
            step(1);
            n++;
        end
        check("two_outstanding", 32'(busq.size()), 32'd2);
        flush_to(32'h8000_1002);
        step(15);
        check("flush_first_seen", 32'(got_first), 32'd1);
        check("flush_first_pc", first_pc, 32'h8000_1000);

        // Bus error at 0x80000008.
        lat_min = 1;
        lat_max = 1;
        err_addr_en = 1'b1;
        err_addr = 32'h8000_0008;
        flush_to(RST_PC);
        step(25);
        check("err_pc", err_pc, 32'h8000_0008);
        check("err_req_idle", 32'(o_ifu_req_valid), 32'd0);
        check("err_drained", 32'(o_inst_valid), 32'd0);
        err_addr_en = 1'b0;
        flush_to(32'h8000_0100);
        step(10);
        check("resume_first_pc", first_pc, 32'h8000_0100);

        // Address wrap.
        saw_wrap = 1'b0;
        flush_to(32'hFFFF_FFF8);
        step(15);
        check("wrap_seen", 32'(saw_wrap), 32'd1);

        // Random traffic.
        p_req_rdy = 70;
        p_inst_rdy = 60;
        p_flush = 2;
        lat_min = 1;
        lat_max = 4;
        err_rand = 1'b1;
        step(3000);

        p_flush = 0;
        err_rand = 1'b0;
        p_req_rdy = 100;
        p_inst_rdy = 100;
        flush_to(RST_PC);
        step(30);
        check("end_first_pc", first_pc, RST_PC);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
